block_mem_responder: RTL and testbench



---
 rtl/block_mem_responder_pkg.sv | 30 +++
 rtl/block_mem_responder_counter.sv | 29 ++
 rtl/block_mem_responder.sv | 153 +++++++++++++++
 tb/tb_block_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_responder_pkg.sv
// Shared encodings for the block memory responder: request opcodes, FSM states
// and block geometry.
package block_mem_responder_pkg;

    localparam int OFFSET_BITS     = 2;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        OP_READ       = 2'b00,
        OP_WRITE      = 2'b01,
        OP_EVICT_FILL = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PH1  = 2'b01,
        PH2  = 2'b10,
        DONE = 2'b11
    } state_e;

    // The reserved opcode 2'b11 is served as a plain READ.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return OP_WRITE;
            2'b10:   return OP_EVICT_FILL;
            default: return OP_READ;
        endcase
    endfunction

endpackage

// File: rtl/block_mem_responder_counter.sv
// Phase latency down-counter: load LATENCY-1, count down while enabled,
// and flag when the count has reached zero.
module mem_latency_counter #(
    parameter int LATENCY = 4
) (
    input  logic i_clk,
    input  logic i_areset,
    input  logic i_load,
    input  logic i_enable,
    output logic o_zero
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= CW'(LATENCY - 1);
        end else if (i_enable && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/block_mem_responder.sv
// Main-memory responder for cache refills and write-backs: block-granular READ,
// WRITE and EVICT_FILL with a fixed per-phase access latency.
//
// state | meaning
// IDLE  | waiting for i_req
// PH1   | first access phase (read, write, or victim write for EVICT_FILL)
// PH2   | fill read of EVICT_FILL
// DONE  | one-cycle completion; a held i_req is taken on the exit edge
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int BUS_WIDTH     = 32,
    parameter int ADDRESS_WIDTH = 10,
    parameter int BLOCK_WIDTH   = 128,
    parameter int LATENCY       = 4,
    parameter int MEM_DEPTH     = 2 ** (ADDRESS_WIDTH - 2)
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    input  logic                     i_req,
    input  logic [1:0]               i_op,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_address,
    input  logic [BLOCK_WIDTH-1:0]   i_wdata,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [BLOCK_WIDTH-1:0]   o_rdata
);

    localparam int INDEX_BITS = ADDRESS_WIDTH - OFFSET_BITS;

    state_e                  state_q, state_d;
    op_e                     op_q;
    logic [INDEX_BITS-1:0]   idx_q, wb_idx_q, mem_widx;
    logic [BLOCK_WIDTH-1:0]  wdata_q;
    logic                    accept, cnt_load, cnt_en, cnt_zero, mem_we, rd_en;
    logic [BLOCK_WIDTH-1:0]  mem_rd [MEM_DEPTH];
    logic                    unused_offset_bits;

    assign unused_offset_bits = ^{i_address[OFFSET_BITS-1:0], i_wb_address[OFFSET_BITS-1:0]};

    // Word w of the memory resets to the value w.
    function automatic logic [BLOCK_WIDTH-1:0] init_block(input int blk);
        logic [BLOCK_WIDTH-1:0] v;
        v = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            v[w*BUS_WIDTH +: BUS_WIDTH] = BUS_WIDTH'(blk * WORDS_PER_BLOCK + w);
        end
        return v;
    endfunction

    mem_latency_counter #(.LATENCY(LATENCY)) u_counter (
        .i_clk    (i_clk),
        .i_areset (i_areset),
        .i_load   (cnt_load),
        .i_enable (cnt_en),
        .o_zero   (cnt_zero)
    );

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        mem_we   = 1'b0;
        mem_widx = idx_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (i_req) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = PH1;
                end
            end
            PH1: begin
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = DONE;
                    case (op_q)
                        OP_WRITE: mem_we = 1'b1;
                        OP_EVICT_FILL: begin
                            mem_we   = 1'b1;
                            mem_widx = wb_idx_q;
                            cnt_load = 1'b1;
                            state_d  = PH2;
                        end
                        default: rd_en = 1'b1;
                    endcase
                end
            end
            PH2: begin
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            op_q     <= OP_READ;
            idx_q    <= '0;
            wb_idx_q <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            op_q     <= decode_op(i_op);
            idx_q    <= i_address[ADDRESS_WIDTH-1:OFFSET_BITS];
            wb_idx_q <= i_wb_address[ADDRESS_WIDTH-1:OFFSET_BITS];
            wdata_q  <= i_wdata;
        end
    end

    for (genvar b = 0; b < MEM_DEPTH; b++) begin : g_blk
        logic [BLOCK_WIDTH-1:0] blk_q;
        always_ff @(posedge i_clk or posedge i_areset) begin
            if (i_areset) begin
                blk_q <= init_block(b);
            end else if (mem_we && (mem_widx == INDEX_BITS'(b))) begin
                blk_q <= wdata_q;
            end
        end
        assign mem_rd[b] = blk_q;
    end

    // Fill read of EVICT_FILL happens a full phase after the victim write,
    // so a same-block eviction naturally returns the new data.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_rdata <= '0;
        end else if (rd_en) begin
            o_rdata <= mem_rd[idx_q];
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: directed and random traffic
// against a block-array reference model, plus a LATENCY=1 instance.
module tb_block_mem_responder;

    localparam int AW = 10;
    localparam int BW = 128;
    localparam int L  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset;
    logic          req;
    logic [1:0]    op;
    logic [AW-1:0] addr, wb_addr;
    logic [BW-1:0] wdata;
    logic          busy, done;
    logic [BW-1:0] rdata;

    logic          req1;
    logic [1:0]    op1 = 2'b00;
    logic [AW-1:0] addr1, wb_addr1 = '0;
    logic [BW-1:0] wdata1 = '0;
    logic          busy1, done1;
    logic [BW-1:0] rdata1;

    int total = 0;
    int bad   = 0;
    int done_count = 0;

    logic [BW-1:0] ref_mem [256];
    logic [BW-1:0] exp_rdata;

    block_mem_responder #(.LATENCY(L)) dut (
        .i_clk(clk), .i_areset(areset), .i_req(req), .i_op(op),
        .i_address(addr), .i_wb_address(wb_addr), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_rdata(rdata)
    );

    block_mem_responder #(.LATENCY(1)) dut1 (
        .i_clk(clk), .i_areset(areset), .i_req(req1), .i_op(op1),
        .i_address(addr1), .i_wb_address(wb_addr1), .i_wdata(wdata1),
        .o_busy(busy1), .o_done(done1), .o_rdata(rdata1)
    );

    always @(posedge clk) if (done === 1'b1) done_count++;

    function automatic logic [BW-1:0] init_block(input int b);
        logic [BW-1:0] v;
        for (int w = 0; w < 4; w++) v[w*32 +: 32] = 32'(b * 4 + w);
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 256; b++) ref_mem[b] = init_block(b);
        exp_rdata = '0;
    endtask

    // Reference behaviour of one accepted request; returns expected latency.
    task automatic model_op(input logic [1:0] o, input logic [AW-1:0] a,
                            input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                            output int exp_lat);
        exp_lat = L;
        case (o)
            2'b01: ref_mem[a / 4] = wd;
            2'b10: begin
                ref_mem[wa / 4] = wd;
                exp_rdata = ref_mem[a / 4];
                exp_lat = 2 * L;
            end
            default: exp_rdata = ref_mem[a / 4];
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [AW-1:0] a,
                          input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                          output int lat, output logic [BW-1:0] rd,
                          output logic busy_after);
        lat = -1;
        rd = 'x;
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wb_addr = wa; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; op = 2'($urandom); addr = AW'($urandom);
        wb_addr = AW'($urandom); wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                rd = rdata;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset();
        areset = 1'b1; req = 1'b0; req1 = 1'b0; op = '0;
        addr = '0; wb_addr = '0; wdata = '0; addr1 = '0;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        @(negedge clk);
        areset = 1'b0;
        model_reset();
    endtask

    task automatic test_read();
        int lat, el; logic [BW-1:0] rd; logic ba;
        model_op(2'b00, 10'h014, '0, '0, el);
        run_op(2'b00, 10'h014, '0, '0, lat, rd, ba);
        total++; if (lat !== 4) begin bad++; $display("FAIL read_latency: got %0d want 4", lat); end
        total++; if (rd !== {32'h17, 32'h16, 32'h15, 32'h14}) begin bad++; $display("FAIL read_data: got %h want 00000017000000160000001500000014", rd); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL read_busy_after: got %b want 0", ba); end
    endtask

    task automatic test_write_read();
        int lat, el; logic [BW-1:0] rd; logic ba; logic [BW-1:0] wd;
        wd = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        model_op(2'b01, 10'h020, '0, wd, el);
        run_op(2'b01, 10'h020, '0, wd, lat, rd, ba);
        total++; if (lat !== el) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, el); end
        total++; if (rd !== exp_rdata) begin bad++; $display("FAIL write_rdata_held: got %h want %h", rd, exp_rdata); end
        model_op(2'b00, 10'h023, '0, '0, el);
        run_op(2'b00, 10'h023, '0, '0, lat, rd, ba);
        total++; if (rd !== wd) begin bad++; $display("FAIL write_readback: got %h want %h", rd, wd); end
    endtask

    task automatic test_evict_fill();
        int lat, el; logic [BW-1:0] rd, wd; logic ba;
        model_op(2'b10, 10'h080, 10'h040, '1, el);
        run_op(2'b10, 10'h080, 10'h040, '1, lat, rd, ba);
        total++; if (lat !== 2 * L) begin bad++; $display("FAIL evict_latency: got %0d want %0d", lat, 2 * L); end
        total++; if (rd !== {32'h83, 32'h82, 32'h81, 32'h80}) begin bad++; $display("FAIL evict_fill_data: got %h want 00000083000000820000008100000080", rd); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL evict_busy_after: got %b want 0", ba); end
        model_op(2'b00, 10'h040, '0, '0, el);
        run_op(2'b00, 10'h040, '0, '0, lat, rd, ba);
        total++; if (rd !== '1) begin bad++; $display("FAIL evict_victim_readback: got %h want all ones", rd); end
        wd = {$urandom, $urandom, $urandom, $urandom};
        model_op(2'b10, 10'h0C7, 10'h0C4, wd, el);
        run_op(2'b10, 10'h0C7, 10'h0C4, wd, lat, rd, ba);
        total++; if (rd !== wd) begin bad++; $display("FAIL evict_same_block: got %h want %h", rd, wd); end
    endtask

    task automatic test_random();
        int lat, el; logic [BW-1:0] rd, wd; logic ba; logic [1:0] o; logic [AW-1:0] a, wa;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = AW'($urandom_range(0, 63));
            wa = AW'($urandom_range(0, 63));
            wd = {$urandom, $urandom, $urandom, $urandom};
            model_op(o, a, wa, wd, el);
            run_op(o, a, wa, wd, lat, rd, ba);
            total++; if (lat !== el) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, el); end
            total++; if (rd !== exp_rdata) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rd, exp_rdata); end
        end
    endtask

    // Requests are held high; accepts happen every L+1 cycles while held.
    task automatic test_req_held();
        int next_acc, pulses, accepts; int due_q[$]; logic [BW-1:0] dat_q[$];
        next_acc = 0; pulses = 0; accepts = 0;
        @(negedge clk);
        for (int c = 0; c < 12 + L + 3; c++) begin
            req = (c < 12);
            op = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            addr = AW'($urandom);
            if (c < 12 && c == next_acc) begin
                due_q.push_back(c + L);
                dat_q.push_back(ref_mem[addr / 4]);
                accepts++;
                next_acc = c + L + 1;
            end
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                total++;
                if (due_q.size() == 0 || due_q[0] != c) begin
                    bad++; $display("FAIL held_done_timing: done after edge %0d, none expected there", c);
                end else if (rdata !== dat_q[0]) begin
                    bad++; $display("FAIL held_rdata: got %h want %h", rdata, dat_q[0]);
                end
                if (due_q.size() != 0) begin void'(due_q.pop_front()); void'(dat_q.pop_front()); end
            end
        end
        req = 1'b0;
        total++; if (pulses != accepts) begin bad++; $display("FAIL held_pulse_count: got %0d want %0d", pulses, accepts); end
        if (dat_q.size() != 0) exp_rdata = dat_q[$];
        else if (accepts != 0) exp_rdata = rdata;
    endtask

    task automatic test_reset_mid_write();
        int lat, el, dc; logic [BW-1:0] rd; logic ba;
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 10'h100; wdata = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dc = done_count;
        areset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
        repeat (2) @(negedge clk);
        areset = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (done_count != dc) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_count - dc); end
        model_reset();
        model_op(2'b00, 10'h100, '0, '0, el);
        run_op(2'b00, 10'h100, '0, '0, lat, rd, ba);
        total++; if (rd !== {32'h103, 32'h102, 32'h101, 32'h100}) begin bad++; $display("FAIL midrst_readback: got %h want 00000103000001020000010100000100", rd); end
    endtask

    task automatic test_latency1();
        int pulses; int due_q[$]; logic [BW-1:0] dat_q[$];
        pulses = 0;
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            req1 = (c < 6);
            addr1 = AW'($urandom);
            if (c < 6 && (c % 2) == 0) begin
                due_q.push_back(c + 1);
                dat_q.push_back(init_block(int'(addr1 / 4)));
            end
            @(posedge clk);
            @(negedge clk);
            if (done1 === 1'b1) begin
                pulses++;
                total++;
                if (due_q.size() == 0 || due_q[0] != c) begin
                    bad++; $display("FAIL lat1_done_timing: done after edge %0d, none expected there", c);
                end else if (rdata1 !== dat_q[0]) begin
                    bad++; $display("FAIL lat1_rdata: got %h want %h", rdata1, dat_q[0]);
                end
                if (due_q.size() != 0) begin void'(due_q.pop_front()); void'(dat_q.pop_front()); end
            end
        end
        req1 = 1'b0;
        total++; if (pulses != 3) begin bad++; $display("FAIL lat1_pulse_count: got %0d want 3", pulses); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_evict_fill();
        test_random();
        test_req_held();
        test_reset_mid_write();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
